// File: rtl/spectrum_frame_source.sv
// Frame buffer that replays FRAME_LEN signed samples as an AXI-Stream master.
// A one-cycle-latency RAM feeds a 2-entry skid stage so backpressure never costs a bubble.
module spectrum_frame_source #(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 1024,
    parameter int AW        = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [2*DW-1:0] wr_data,
    input  logic            start,
    input  logic            continuous,
    output logic            busy,
    output logic            frame_done,
    output logic            wr_reject,
    output logic [2*DW-1:0] tdata_m,
    output logic            tuser_m,
    output logic            tlast_m,
    output logic            tvalid_m,
    input  logic            tready_m
);

    // state    | meaning
    // S_IDLE   | waiting for start; buffer writable
    // S_PRIME  | issue read of index 0 for a new frame
    // S_STREAM | issue reads as skid space allows; leave on last-beat handshake
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            rd_done_q, rd_done_d;
    logic            rd_issue;
    logic            wr_reject_q, wr_reject_d;

    logic [2*DW-1:0] mem [FRAME_LEN];
    logic [2*DW-1:0] rd_data_q;
    logic [AW-1:0]   rd_idx_q;
    logic            rd_vld_q;

    logic [2*DW-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic [AW-1:0]   e0_idx_q, e0_idx_d, e1_idx_q, e1_idx_d;
    logic [1:0]      cnt_q, cnt_d, cnt_mid;
    logic [2:0]      occ_next;
    logic            out_valid, pop, last_pop, space_ok;

    assign out_valid  = (cnt_q != 2'd0);
    assign tvalid_m   = out_valid & ce;
    assign pop        = tvalid_m & tready_m;
    assign last_pop   = pop & (e0_idx_q == LAST_IDX);
    assign frame_done = last_pop;
    assign busy       = (state_q != S_IDLE);
    assign wr_reject  = wr_reject_q;
    assign tdata_m    = e0_data_q;
    assign tuser_m    = out_valid & (e0_idx_q == '0);
    assign tlast_m    = out_valid & (e0_idx_q == LAST_IDX);

    // A read issued now lands next cycle, so leave room for it even if nothing pops then.
    assign occ_next = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    assign space_ok = (occ_next <= 3'd1);

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        rd_done_d   = rd_done_q;
        rd_issue    = 1'b0;
        wr_reject_d = wr_reject_q | (wr_en & busy);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_PRIME;
                    rd_ptr_d    = '0;
                    rd_done_d   = 1'b0;
                    wr_reject_d = 1'b0;
                end
            end
            S_PRIME: begin
                rd_issue = 1'b1;
                rd_ptr_d = rd_ptr_q + AW'(1);
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                if (!rd_done_q && space_ok) begin
                    rd_issue = 1'b1;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (rd_ptr_q == LAST_IDX) rd_done_d = 1'b1;
                end
                if (last_pop) begin
                    if (continuous) begin
                        state_d   = S_PRIME;
                        rd_ptr_d  = '0;
                        rd_done_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        e0_data_d = e0_data_q;
        e0_idx_d  = e0_idx_q;
        e1_data_d = e1_data_q;
        e1_idx_d  = e1_idx_q;
        cnt_mid   = cnt_q - {1'b0, pop};
        if (pop) begin
            e0_data_d = e1_data_q;
            e0_idx_d  = e1_idx_q;
        end
        if (rd_vld_q) begin
            if (cnt_mid == 2'd0) begin
                e0_data_d = rd_data_q;
                e0_idx_d  = rd_idx_q;
            end else begin
                e1_data_d = rd_data_q;
                e1_idx_d  = rd_idx_q;
            end
        end
        cnt_d = cnt_mid + {1'b0, rd_vld_q};
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (ce && wr_en && !busy) mem[wr_addr] <= wr_data;
        if (ce && rd_issue) rd_data_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            rd_done_q   <= 1'b0;
            wr_reject_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            e0_data_q   <= '0;
            e0_idx_q    <= '0;
            e1_data_q   <= '0;
            e1_idx_q    <= '0;
            cnt_q       <= 2'd0;
        end else if (ce) begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_done_q   <= rd_done_d;
            wr_reject_q <= wr_reject_d;
            rd_vld_q    <= rd_issue;
            if (rd_issue) rd_idx_q <= rd_ptr_q;
            e0_data_q   <= e0_data_d;
            e0_idx_q    <= e0_idx_d;
            e1_data_q   <= e1_data_d;
            e1_idx_q    <= e1_idx_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_spectrum_frame_source.sv
// Directed bench for spectrum_frame_source: ramp frame replay under backpressure,
// continuous mode, write rejection, mid-frame reset and clock-enable hold.
module tb_spectrum_frame_source;
    localparam int DW = 16;
    localparam int FL = 1024;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            ce = 1'b1;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic            start = 1'b0;
    logic            continuous = 1'b0;
    logic            tready_m = 1'b1;
    logic            busy, frame_done, wr_reject, tuser_m, tlast_m, tvalid_m;
    logic [2*DW-1:0] tdata_m;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spectrum_frame_source #(.DW(DW), .FRAME_LEN(FL), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .continuous(continuous), .busy(busy),
        .frame_done(frame_done), .wr_reject(wr_reject), .tdata_m(tdata_m),
        .tuser_m(tuser_m), .tlast_m(tlast_m), .tvalid_m(tvalid_m), .tready_m(tready_m)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < FL; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step(); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
        n_total++; if (wr_reject !== 1'b0) $display("FAIL reset_wr_reject: got %b want 0", wr_reject); else n_pass++;
        n_total++; if (tvalid_m !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tvalid_m); else n_pass++;
        n_total++; if (tuser_m !== 1'b0) $display("FAIL reset_tuser: got %b want 0", tuser_m); else n_pass++;
        n_total++; if (tlast_m !== 1'b0) $display("FAIL reset_tlast: got %b want 0", tlast_m); else n_pass++;
        n_total++; if (tdata_m !== 32'd0) $display("FAIL reset_tdata: got %h want 0", tdata_m); else n_pass++;
        reset_n = 1'b1;
        load_ramp();
        #1;
        n_total++; if (wr_reject !== 1'b0) $display("FAIL idle_write_reject: got %b want 0", wr_reject); else n_pass++;
    endtask

    task automatic test_basic();
        tready_m = 1'b1;
        pulse_start();
        #1;
        n_total++; if (tvalid_m !== 1'b0) $display("FAIL lat_c1_tvalid: got %b want 0", tvalid_m); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL lat_busy: got %b want 1", busy); else n_pass++;
        step(); #1;
        n_total++; if (tvalid_m !== 1'b0) $display("FAIL lat_c2_tvalid: got %b want 0", tvalid_m); else n_pass++;
        for (int k = 0; k < FL; k++) begin
            step(); #1;
            n_total++; if (tvalid_m !== 1'b1) $display("FAIL basic_tvalid[%0d]: got %b want 1", k, tvalid_m); else n_pass++;
            n_total++; if (tdata_m !== 32'(k)) $display("FAIL basic_tdata[%0d]: got %0d want %0d", k, tdata_m, k); else n_pass++;
            n_total++; if (tuser_m !== (k == 0)) $display("FAIL basic_tuser[%0d]: got %b", k, tuser_m); else n_pass++;
            n_total++; if (tlast_m !== (k == FL-1)) $display("FAIL basic_tlast[%0d]: got %b", k, tlast_m); else n_pass++;
            n_total++; if (frame_done !== (k == FL-1)) $display("FAIL basic_frame_done[%0d]: got %b", k, frame_done); else n_pass++;
        end
        step(); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_end_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (tvalid_m !== 1'b0) $display("FAIL basic_end_tvalid: got %b want 0", tvalid_m); else n_pass++;
    endtask

    task automatic test_random_ready();
        int exp_i = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [2*DW-1:0] held = '0;
        pulse_start();
        while (exp_i < FL && cyc < 6000) begin
            tready_m = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                n_total++; if (tvalid_m !== 1'b1) $display("FAIL bp_valid_drop: got %b want 1", tvalid_m); else n_pass++;
                n_total++; if (tdata_m !== held) $display("FAIL bp_stable: got %h want %h", tdata_m, held); else n_pass++;
            end
            stalled = 1'b0;
            if (tvalid_m) begin
                if (tready_m) begin
                    n_total++; if (tdata_m !== 32'(exp_i)) $display("FAIL bp_tdata: got %0d want %0d", tdata_m, exp_i); else n_pass++;
                    n_total++; if (tuser_m !== (exp_i == 0)) $display("FAIL bp_tuser[%0d]: got %b", exp_i, tuser_m); else n_pass++;
                    n_total++; if (frame_done !== (exp_i == FL-1)) $display("FAIL bp_frame_done[%0d]: got %b", exp_i, frame_done); else n_pass++;
                    exp_i++;
                end else begin
                    stalled = 1'b1;
                    held = tdata_m;
                end
            end
            step();
            cyc++;
        end
        n_total++; if (exp_i != FL) $display("FAIL bp_beats: got %0d want %0d", exp_i, FL); else n_pass++;
        tready_m = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL bp_end_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_continuous();
        int fd = 0;
        int exp_i = 0;
        int gap = 0;
        int cyc = 0;
        bit in_gap = 1'b0;
        tready_m = 1'b1;
        continuous = 1'b1;
        pulse_start();
        while (fd < 3 && cyc < 5000) begin
            #1;
            if (tvalid_m) begin
                if (in_gap) begin
                    n_total++; if (gap > 2) $display("FAIL cont_gap: got %0d want <=2", gap); else n_pass++;
                    in_gap = 1'b0;
                end
                n_total++; if (tdata_m !== 32'(exp_i)) $display("FAIL cont_tdata: got %0d want %0d", tdata_m, exp_i); else n_pass++;
                if (exp_i == 0) begin
                    n_total++; if (tuser_m !== 1'b1) $display("FAIL cont_tuser: got %b want 1", tuser_m); else n_pass++;
                    if (fd == 2) continuous = 1'b0;
                end
                if (exp_i == FL-1) begin
                    n_total++; if (frame_done !== 1'b1) $display("FAIL cont_frame_done: got %b want 1", frame_done); else n_pass++;
                    fd++; exp_i = 0; in_gap = 1'b1; gap = 0;
                end else begin
                    exp_i++;
                end
            end else if (in_gap) begin
                gap++;
            end
            if (fd < 3) step();
            cyc++;
        end
        n_total++; if (fd != 3) $display("FAIL cont_frames: got %0d want 3", fd); else n_pass++;
        step(); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL cont_end_busy: got %b want 0", busy); else n_pass++;
        step(); step(); step(); #1;
        n_total++; if (tvalid_m !== 1'b0) $display("FAIL cont_idle_tvalid: got %b want 0", tvalid_m); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL cont_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_write_reject();
        int exp_i = 0;
        int cyc = 0;
        bit done = 1'b0;
        tready_m = 1'b1;
        pulse_start();
        while (!done && cyc < 2000) begin
            wr_en = 1'b0;
            #1;
            if (tvalid_m) begin
                n_total++; if (tdata_m !== 32'(exp_i)) $display("FAIL wrj_tdata: got %h want %0d", tdata_m, exp_i); else n_pass++;
                if (exp_i == 2) begin
                    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'h7FFF_8000;
                end
                if (exp_i == 3) begin
                    n_total++; if (wr_reject !== 1'b1) $display("FAIL wrj_set: got %b want 1", wr_reject); else n_pass++;
                end
                if (exp_i == FL-1) done = 1'b1;
                exp_i++;
            end
            step();
            cyc++;
        end
        wr_en = 1'b0;
        n_total++; if (!done) $display("FAIL wrj_frame_timeout: got %0d beats want %0d", exp_i, FL); else n_pass++;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL wrj_idle_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (wr_reject !== 1'b1) $display("FAIL wrj_sticky: got %b want 1", wr_reject); else n_pass++;
        step();
        pulse_start();
        #1;
        n_total++; if (wr_reject !== 1'b0) $display("FAIL wrj_clear: got %b want 0", wr_reject); else n_pass++;
        exp_i = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 2000) begin
            if (tvalid_m) begin
                if (exp_i == 5) begin
                    n_total++; if (tdata_m !== 32'd5) $display("FAIL wrj_buf5: got %h want 5", tdata_m); else n_pass++;
                end
                if (exp_i == FL-1) done = 1'b1;
                exp_i++;
            end
            step(); #1;
            cyc++;
        end
        n_total++; if (!done) $display("FAIL wrj_frame2_timeout: got %0d beats want %0d", exp_i, FL); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int exp_i = 0;
        int cyc = 0;
        int seen_valid = 0;
        int seen_done = 0;
        bit hit = 1'b0;
        tready_m = 1'b1;
        pulse_start();
        while (!hit && cyc < 2000) begin
            #1;
            if (tvalid_m) begin
                if (exp_i == 500) begin
                    hit = 1'b1;
                    n_total++; if (tdata_m !== 32'd500) $display("FAIL rst_beat500: got %0d want 500", tdata_m); else n_pass++;
                    reset_n = 1'b0;
                end else begin
                    exp_i++;
                end
            end
            step();
            cyc++;
        end
        reset_n = 1'b1;
        n_total++; if (!hit) $display("FAIL rst_reach_timeout: got %0d want 500", exp_i); else n_pass++;
        #1;
        n_total++; if (tvalid_m !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", tvalid_m); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (tvalid_m) seen_valid++;
            if (frame_done) seen_done++;
            step(); #1;
        end
        n_total++; if (seen_valid != 0) $display("FAIL rst_quiet_valid: got %0d want 0", seen_valid); else n_pass++;
        n_total++; if (seen_done != 0) $display("FAIL rst_no_frame_done: got %0d want 0", seen_done); else n_pass++;
        pulse_start();
        step(); step(); #1;
        n_total++; if (tvalid_m !== 1'b1) $display("FAIL rst_restart_tvalid: got %b want 1", tvalid_m); else n_pass++;
        n_total++; if (tdata_m !== 32'd0) $display("FAIL rst_restart_tdata: got %0d want 0", tdata_m); else n_pass++;
        n_total++; if (tuser_m !== 1'b1) $display("FAIL rst_restart_tuser: got %b want 1", tuser_m); else n_pass++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_ce_hold();
        int exp_i = 0;
        int cyc = 0;
        int seen_valid = 0;
        int seen_idle = 0;
        bit hit = 1'b0;
        tready_m = 1'b1;
        pulse_start();
        while (!hit && cyc < 2000) begin
            #1;
            if (tvalid_m) begin
                if (exp_i == 100) begin
                    ce = 1'b0;
                    hit = 1'b1;
                end else begin
                    n_total++; if (tdata_m !== 32'(exp_i)) $display("FAIL ce_pre_tdata: got %0d want %0d", tdata_m, exp_i); else n_pass++;
                    exp_i++;
                end
            end
            if (!hit) step();
            cyc++;
        end
        n_total++; if (!hit) $display("FAIL ce_reach_timeout: got %0d want 100", exp_i); else n_pass++;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (tvalid_m) seen_valid++;
            if (!busy) seen_idle++;
            step(); #1;
        end
        n_total++; if (seen_valid != 0) $display("FAIL ce_tvalid_low: got %0d cycles valid want 0", seen_valid); else n_pass++;
        n_total++; if (seen_idle != 0) $display("FAIL ce_busy_hold: got %0d idle cycles want 0", seen_idle); else n_pass++;
        ce = 1'b1;
        #1;
        for (int k = 100; k < FL; k++) begin
            n_total++; if (tvalid_m !== 1'b1) $display("FAIL ce_resume_tvalid[%0d]: got %b want 1", k, tvalid_m); else n_pass++;
            n_total++; if (tdata_m !== 32'(k)) $display("FAIL ce_resume_tdata: got %0d want %0d", tdata_m, k); else n_pass++;
            n_total++; if (frame_done !== (k == FL-1)) $display("FAIL ce_frame_done[%0d]: got %b", k, frame_done); else n_pass++;
            step(); #1;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL ce_end_busy: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_continuous();
        test_write_reject();
        test_reset_mid();
        test_ce_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spectrum_frame_source.md
Name: spectrum_frame_source

Overview:
- Frame buffer and AXI-Stream transmitter that feeds spectrum frames into the prominence analysis datapath.
- Software or upstream logic loads FRAME_LEN signed samples through a simple write port.
- On a trigger, the block replays the frame as an AXI-Stream master:
  - tuser marks the first sample; tlast marks the last.
  - Backpressure is honoured at one sample per cycle throughput.
- Used for closed-loop test of analysis blocks and for offline replay of captured spectra.

Parameters:
DW, 16, half-width of a sample; stream samples are 2*DW bits signed
FRAME_LEN, 1024, samples per frame (power of two, >= 4)
AW, 10, buffer address width, log2(FRAME_LEN)

Ports:
clk  in  1  global clock
reset_n  in  1  synchronous, active-low reset
ce  in  1  clock enable; when low all state holds and tvalid_m is forced low
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_data  in  2*DW  buffer write data
start  in  1  one-cycle trigger to stream a frame
continuous  in  1  when high, restart automatically after each frame
busy  out  1  high from accepted start until the final frame completes
frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted
wr_reject  out  1  sticky; set when a write arrives while busy, cleared by an accepted start
tdata_m  out  2*DW  stream sample (signed)
tuser_m  out  1  high on sample index 0
tlast_m  out  1  high on sample index FRAME_LEN-1
tvalid_m  out  1  stream valid
tready_m  in  1  stream ready

Behaviour:
- Reset (reset_n low at clk edge):
  - FSM goes to IDLE; read pointer cleared; output stage emptied.
  - busy, frame_done, wr_reject, tvalid_m, tuser_m and tlast_m are all 0; tdata_m is 0.
  - Buffer contents are not cleared.
  - Reset mid-frame abandons the frame: tvalid_m is low from the next cycle; no frame_done is issued.
- ce:
  - All registers update only when ce=1.
  - tvalid_m = out_valid & ce, and a beat transfers only when tvalid_m & tready_m.
- Buffer:
  - Synchronous single-write / single-read RAM, FRAME_LEN x 2*DW, one-cycle read latency.
  - A write commits when wr_en & ce & !busy.
  - wr_en while busy is dropped and sets wr_reject.
- FSM states:
  - IDLE: start & ce -> PRIME. Read address 0 is issued, busy=1, wr_reject cleared. start has no effect in any other state.
  - PRIME: read data captured into the output stage -> STREAM. First tvalid_m is asserted 2 cycles after start is sampled.
  - STREAM: the read pointer advances whenever the output stage will have a free slot. A 2-entry skid buffer in the output stage gives:
    - no bubble under continuous tready_m;
    - tdata_m/tuser_m/tlast_m stable while tvalid_m & !tready_m.
  - When the beat with index FRAME_LEN-1 is accepted:
    - frame_done pulses.
    - continuous=1 -> PRIME with read address 0. The gap is at most 2 cycles of tvalid_m low.
    - continuous=0 -> IDLE, busy=0 on the next cycle.
- continuous is sampled only at frame end. Deasserting it mid-frame completes the current frame, then the block stops.
- Index arithmetic:
  - The read pointer is AW bits and wraps FRAME_LEN-1 -> 0.
  - tuser_m/tlast_m are derived from the sample index carried alongside the data through the skid buffer, not from the read pointer.
- tvalid_m never drops without a handshake, except on reset or ce=0.
- A simultaneous last-beat acceptance and start pulse: start is ignored (busy still 1 that cycle).

Test Plan:
- Load buffer[i] = i (i=0..1023), pulse start, tready_m=1 constant:
  - first tvalid_m 2 cycles after start, tdata_m=0 with tuser_m=1;
  - 1024 contiguous beats, last tdata_m=1023 with tlast_m=1;
  - frame_done pulses on the same cycle; busy=0 on the next cycle.
- Same frame with tready_m toggled randomly (50%) -> sequence 0..1023 in order, no duplicates or drops; tdata_m stable whenever tvalid_m & !tready_m.
- continuous=1 for 3 frames, then cleared -> 3 frame_done pulses; each inter-frame gap ≤2 cycles; tuser_m is set on each frame's first beat; IDLE after frame 3.
- Write 0x7FFF_8000 at addr 5 during streaming:
  - wr_reject=1; replay still shows the original value at index 5;
  - the next start clears wr_reject.
- Assert reset_n=0 for one cycle at beat 500 -> tvalid_m=0 and busy=0 next cycle; no frame_done; a subsequent start replays from index 0.
- Hold ce=0 for 10 cycles mid-frame with tready_m=1 -> tvalid_m low and no index advance; streaming resumes at the next index when ce returns.
